alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Hardwired control unit that sequences the datapath through fetch (T0-T2) and execute (T3-T6) steps for register-format ALU instructions.
- Replaces hand-driven control in datapath benches.
- Sits beside the datapath: it reads the IR contents and drives every bus-out, register-in, ALU-select and memory strobe.
- Handles ALU R-format, MUL/DIV, NEG/NOT, NOP and HALT.

Parameters:
- NUM_REGS, 16, general registers R0..R15; width of the reg_in/reg_out one-hot vectors.
- OPC_W, 5, opcode field width (IR[31:27]).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- run  in  1  level; 1 = fetch and execute continuously, 0 = stop at the next instruction boundary.
- ir  in  32  IR register contents: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- PCout, IncPC, MARin, Read, MDRin, MDRout, IRin  out  1 each  fetch strobes.
- Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  execute strobes.
- alu_op  out  13  one-hot ALU select. Bit order 0..12: AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
- reg_out  out  NUM_REGS  one-hot R0out..R15out.
- reg_in  out  NUM_REGS  one-hot R0in..R15in.
- busy  out  1  high in T0..T6.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when an undefined opcode is decoded; cleared only by reset.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- Outputs are Moore-style, decoded from state and ir. Each strobe is high for exactly one full cycle, and the datapath captures on the edge that ends that cycle.
- Reset (reset=0 at an edge): state=IDLE and illegal=0, regardless of the current state, including mid-instruction. In IDLE all strobes, alu_op, reg_in, reg_out, busy and halted are 0.
- IDLE: go to T0 if run=1, else stay in IDLE.
- T0: PCout, MARin, IncPC. IncPC updates PC directly.
- T1: Read, MDRin.
- T2: MDRout, IRin. Then go to T3, except: NOP -> T0 (or IDLE if run=0); HALT -> HALT.
- ir is valid from T3 onward; the sequencer does not latch it.
- 3-operand ALU ops (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL):
  - T3: reg_out[Rb], Yin.
  - T4: reg_out[Rc], alu_op bit, Zin.
  - T5: Zlowout, reg_in[Ra].
  - Then end of instruction.
- MUL, DIV (operands Ra, Rb):
  - T3: reg_out[Ra], Yin.
  - T4: reg_out[Rb], alu_op bit, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Then end of instruction.
- NEG, NOT (Ra <- op Rb):
  - T3: reg_out[Rb], alu_op bit, Zin.
  - T4: Zlowout, reg_in[Ra].
  - Then end of instruction.
- End of instruction: go to T0 if run=1, else IDLE. run is sampled only at this boundary; dropping run mid-instruction never truncates the instruction.
- Undefined opcode in T2: next state HALT, illegal=1, no T3 strobes.
- HALT: all strobes 0, halted=1. Exit only via reset.
- Invariants:
  - At most one reg_out bit, one reg_in bit and one alu_op bit is high in any cycle.
  - Never more than one bus driver (reg_out / PCout / MDRout / Zlowout / Zhighout) per cycle.
  - reg_in and reg_out are never both non-zero in the same cycle.
- Writes to R0 are allowed; R0 is not special-cased.
- Opcodes: ADD 3, SUB 4, AND 5, OR 6, ROR 7, ROL 8, SHR 9, SHRA 10, SHL 11, DIV 15, MUL 16, NEG 17, NOT 18, NOP 26, HALT 27. All others are illegal.

Decomposition:
- Package cpu_isa_pkg holds:
  - opcode localparams;
  - IR field bit positions;
  - state encodings;
  - alu_op bit indices.
  The datapath ALU shares the package.
- Sub-module reg_select_decoder: 4-to-NUM_REGS one-hot decoder with enable, instantiated twice (reg_out, reg_in).

Test Plan:
- SHRA, ir=0x521B8000, run=1, from IDLE:
  - T3: reg_out=0x0008, Yin.
  - T4: reg_out=0x0080, alu_op=0x0080, Zin.
  - T5: Zlowout, reg_in=0x0010.
  - Next cycle is T0 (PCout=1).
- MUL, ir=0x81880000:
  - T3: reg_out=0x0008, Yin.
  - T4: reg_out=0x0002, alu_op=0x0010, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - 7 cycles total.
- NEG, ir=0x89280000:
  - T3: reg_out=0x0020, alu_op=0x0800, Zin.
  - T4: Zlowout, reg_in=0x0004.
  - Next state T0.
- Illegal, ir=0xF8000000:
  - After T2: halted=1, illegal=1; all strobes stay 0 for 10 further cycles.
  - reset=0 for one edge: halted=0, illegal=0, state IDLE.
- reset=0 asserted during T4 of ADD: next cycle all outputs 0, no reg_in pulse ever seen; reset=1 with run=1 resumes at T0.
- run dropped during T3 of ADD: T4 and T5 still occur, then IDLE; busy=0 and no PCout thereafter.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the control unit and the datapath ALU:
// opcodes, IR field positions, sequencer states and ALU select indices.
package cpu_isa_pkg;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'd3;
  localparam opcode_t OP_SUB  = 5'd4;
  localparam opcode_t OP_AND  = 5'd5;
  localparam opcode_t OP_OR   = 5'd6;
  localparam opcode_t OP_ROR  = 5'd7;
  localparam opcode_t OP_ROL  = 5'd8;
  localparam opcode_t OP_SHR  = 5'd9;
  localparam opcode_t OP_SHRA = 5'd10;
  localparam opcode_t OP_SHL  = 5'd11;
  localparam opcode_t OP_DIV  = 5'd15;
  localparam opcode_t OP_MUL  = 5'd16;
  localparam opcode_t OP_NEG  = 5'd17;
  localparam opcode_t OP_NOT  = 5'd18;
  localparam opcode_t OP_NOP  = 5'd26;
  localparam opcode_t OP_HALT = 5'd27;

  localparam int IR_OPC_MSB = 31;
  localparam int IR_RA_MSB  = 26;
  localparam int IR_RB_MSB  = 22;
  localparam int IR_RC_MSB  = 18;
  localparam int REG_SEL_W  = 4;

  localparam int ALU_AND  = 0;
  localparam int ALU_OR   = 1;
  localparam int ALU_ADD  = 2;
  localparam int ALU_SUB  = 3;
  localparam int ALU_MUL  = 4;
  localparam int ALU_DIV  = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;
  localparam int ALU_W    = 13;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_ALU3    = 3'd1,
    CLS_MULDIV  = 3'd2,
    CLS_UNARY   = 3'd3,
    CLS_NOP     = 3'd4,
    CLS_HALT    = 3'd5
  } op_class_e;

  function automatic op_class_e decode_class(opcode_t opc);
    op_class_e cls;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:        cls = CLS_ALU3;
      OP_MUL, OP_DIV:                         cls = CLS_MULDIV;
      OP_NEG, OP_NOT:                         cls = CLS_UNARY;
      OP_NOP:                                 cls = CLS_NOP;
      OP_HALT:                                cls = CLS_HALT;
      default:                                cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic [ALU_W-1:0] alu_onehot(opcode_t opc);
    logic [ALU_W-1:0] sel;
    sel = '0;
    case (opc)
      OP_AND:  sel[ALU_AND]  = 1'b1;
      OP_OR:   sel[ALU_OR]   = 1'b1;
      OP_ADD:  sel[ALU_ADD]  = 1'b1;
      OP_SUB:  sel[ALU_SUB]  = 1'b1;
      OP_MUL:  sel[ALU_MUL]  = 1'b1;
      OP_DIV:  sel[ALU_DIV]  = 1'b1;
      OP_SHR:  sel[ALU_SHR]  = 1'b1;
      OP_SHRA: sel[ALU_SHRA] = 1'b1;
      OP_SHL:  sel[ALU_SHL]  = 1'b1;
      OP_ROR:  sel[ALU_ROR]  = 1'b1;
      OP_ROL:  sel[ALU_ROL]  = 1'b1;
      OP_NEG:  sel[ALU_NEG]  = 1'b1;
      OP_NOT:  sel[ALU_NOT]  = 1'b1;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface alu_sequencer_if import cpu_isa_pkg::*; #(
  parameter int NUM_REGS = 16
) ();

  logic                run;
  logic [31:0]         ir;
  logic                PCout, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic                Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [ALU_W-1:0]    alu_op;
  logic [NUM_REGS-1:0] reg_out;
  logic [NUM_REGS-1:0] reg_in;
  logic                busy, halted, illegal;

  modport master (
    input  run, ir,
    output PCout, IncPC, MARin, Read, MDRin, MDRout, IRin,
    output Yin, Zin, Zlowout, Zhighout, HIin, LOin,
    output alu_op, reg_out, reg_in, busy, halted, illegal
  );

  modport slave (
    output run, ir,
    input  PCout, IncPC, MARin, Read, MDRin, MDRout, IRin,
    input  Yin, Zin, Zlowout, Zhighout, HIin, LOin,
    input  alu_op, reg_out, reg_in, busy, halted, illegal
  );

endinterface

// File: rtl/reg_select_decoder.sv
// Register-number to one-hot select line decoder; all lines low when disabled.
module reg_select_decoder import cpu_isa_pkg::*; #(
  parameter int NUM_REGS = 16
) (
  input  logic                 en,
  input  logic [REG_SEL_W-1:0] sel,
  output logic [NUM_REGS-1:0]  onehot
);

  // one-hot expansion of the selected register number
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Hardwired fetch/execute control unit for register-format ALU instructions.
// Strobes are decoded from the registered state and the live IR contents.
module alu_sequencer import cpu_isa_pkg::*; #(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  alu_sequencer_if.master  bus
);

  state_e                 state_q, state_d;
  logic                   illegal_q, illegal_d;
  logic [OPC_W-1:0]       opc_s;
  op_class_e              cls_s;
  logic [REG_SEL_W-1:0]   ra_s, rb_s, rc_s;
  state_e                 eoi_state_s;
  logic                   unused_ir_s;

  logic pc_out_s, inc_pc_s, mar_in_s, read_s, mdr_in_s, mdr_out_s, ir_in_s;
  logic y_in_s, z_in_s, zlow_out_s, zhigh_out_s, hi_in_s, lo_in_s;
  logic [ALU_W-1:0]     alu_s;
  logic                 out_en_s, in_en_s;
  logic [REG_SEL_W-1:0] out_sel_s, in_sel_s;

  assign opc_s       = bus.ir[IR_OPC_MSB -: OPC_W];
  assign ra_s        = bus.ir[IR_RA_MSB -: REG_SEL_W];
  assign rb_s        = bus.ir[IR_RB_MSB -: REG_SEL_W];
  assign rc_s        = bus.ir[IR_RC_MSB -: REG_SEL_W];
  assign cls_s       = decode_class(opc_s);
  assign unused_ir_s = ^bus.ir[IR_RC_MSB-REG_SEL_W:0];
  // run is only consulted at an instruction boundary
  assign eoi_state_s = bus.run ? ST_T0 : ST_IDLE;

  // next-state and sticky illegal-opcode flag
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d = ST_T0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_T0: state_d = ST_T1;
      ST_T1: state_d = ST_T2;
      ST_T2: begin
        case (cls_s)
          CLS_NOP:     state_d = eoi_state_s;
          CLS_HALT:    state_d = ST_HALT;
          CLS_ILLEGAL: begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
          default:     state_d = ST_T3;
        endcase
      end
      ST_T3: state_d = ST_T4;
      ST_T4: begin
        if (cls_s == CLS_UNARY) begin
          state_d = eoi_state_s;
        end else begin
          state_d = ST_T5;
        end
      end
      ST_T5: begin
        if (cls_s == CLS_MULDIV) begin
          state_d = ST_T6;
        end else begin
          state_d = eoi_state_s;
        end
      end
      ST_T6:   state_d = eoi_state_s;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // per-step strobe decode
  always_comb begin
    pc_out_s    = 1'b0;
    inc_pc_s    = 1'b0;
    mar_in_s    = 1'b0;
    read_s      = 1'b0;
    mdr_in_s    = 1'b0;
    mdr_out_s   = 1'b0;
    ir_in_s     = 1'b0;
    y_in_s      = 1'b0;
    z_in_s      = 1'b0;
    zlow_out_s  = 1'b0;
    zhigh_out_s = 1'b0;
    hi_in_s     = 1'b0;
    lo_in_s     = 1'b0;
    alu_s       = '0;
    out_en_s    = 1'b0;
    out_sel_s   = '0;
    in_en_s     = 1'b0;
    in_sel_s    = '0;
    case (state_q)
      ST_T0: begin
        pc_out_s = 1'b1;
        mar_in_s = 1'b1;
        inc_pc_s = 1'b1;
      end
      ST_T1: begin
        read_s   = 1'b1;
        mdr_in_s = 1'b1;
      end
      ST_T2: begin
        mdr_out_s = 1'b1;
        ir_in_s   = 1'b1;
      end
      ST_T3: begin
        case (cls_s)
          CLS_ALU3: begin
            out_en_s  = 1'b1;
            out_sel_s = rb_s;
            y_in_s    = 1'b1;
          end
          CLS_MULDIV: begin
            out_en_s  = 1'b1;
            out_sel_s = ra_s;
            y_in_s    = 1'b1;
          end
          CLS_UNARY: begin
            out_en_s  = 1'b1;
            out_sel_s = rb_s;
            alu_s     = alu_onehot(opc_s);
            z_in_s    = 1'b1;
          end
          default: out_en_s = 1'b0;
        endcase
      end
      ST_T4: begin
        case (cls_s)
          CLS_ALU3: begin
            out_en_s  = 1'b1;
            out_sel_s = rc_s;
            alu_s     = alu_onehot(opc_s);
            z_in_s    = 1'b1;
          end
          CLS_MULDIV: begin
            out_en_s  = 1'b1;
            out_sel_s = rb_s;
            alu_s     = alu_onehot(opc_s);
            z_in_s    = 1'b1;
          end
          CLS_UNARY: begin
            zlow_out_s = 1'b1;
            in_en_s    = 1'b1;
            in_sel_s   = ra_s;
          end
          default: out_en_s = 1'b0;
        endcase
      end
      ST_T5: begin
        case (cls_s)
          CLS_ALU3: begin
            zlow_out_s = 1'b1;
            in_en_s    = 1'b1;
            in_sel_s   = ra_s;
          end
          CLS_MULDIV: begin
            zlow_out_s = 1'b1;
            lo_in_s    = 1'b1;
          end
          default: out_en_s = 1'b0;
        endcase
      end
      ST_T6: begin
        if (cls_s == CLS_MULDIV) begin
          zhigh_out_s = 1'b1;
          hi_in_s     = 1'b1;
        end else begin
          zhigh_out_s = 1'b0;
        end
      end
      default: out_en_s = 1'b0;
    endcase
  end

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_out_dec (
    .en     (out_en_s),
    .sel    (out_sel_s),
    .onehot (bus.reg_out)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_in_dec (
    .en     (in_en_s),
    .sel    (in_sel_s),
    .onehot (bus.reg_in)
  );

  assign bus.PCout    = pc_out_s;
  assign bus.IncPC    = inc_pc_s;
  assign bus.MARin    = mar_in_s;
  assign bus.Read     = read_s;
  assign bus.MDRin    = mdr_in_s;
  assign bus.MDRout   = mdr_out_s;
  assign bus.IRin     = ir_in_s;
  assign bus.Yin      = y_in_s;
  assign bus.Zin      = z_in_s;
  assign bus.Zlowout  = zlow_out_s;
  assign bus.Zhighout = zhigh_out_s;
  assign bus.HIin     = hi_in_s;
  assign bus.LOin     = lo_in_s;
  assign bus.alu_op   = alu_s;
  assign bus.busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign bus.halted   = (state_q == ST_HALT);
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: per-cycle strobe vectors against hand-derived tables.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.NUM_REGS(16)) bus ();

  alu_sequencer #(.NUM_REGS(16), .OPC_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // strobe vector bit order: PCout IncPC MARin Read MDRin MDRout IRin Yin Zin Zlowout Zhighout HIin LOin
  localparam logic [12:0] F_T0 = 13'h1C00;
  localparam logic [12:0] F_T1 = 13'h0300;
  localparam logic [12:0] F_T2 = 13'h00C0;
  localparam logic [12:0] YIN  = 13'h0020;
  localparam logic [12:0] ZIN  = 13'h0010;
  localparam logic [12:0] ZLO  = 13'h0008;
  localparam logic [12:0] ZHI  = 13'h0004;
  localparam logic [12:0] HIIN = 13'h0002;
  localparam logic [12:0] LOIN = 13'h0001;

  logic [60:0] obs_s;
  assign obs_s = {bus.PCout, bus.IncPC, bus.MARin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
                  bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin,
                  bus.alu_op, bus.reg_out, bus.reg_in, bus.busy, bus.halted, bus.illegal};

  function automatic logic [60:0] ev(logic [12:0] s, logic [12:0] a, logic [15:0] ro,
                                     logic [15:0] ri, logic b, logic h, logic il);
    return {s, a, ro, ri, b, h, il};
  endfunction

  function automatic logic [60:0] fetch(int k);
    logic [12:0] s;
    s = (k == 0) ? F_T0 : (k == 1) ? F_T1 : F_T2;
    return ev(s, 13'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    bus.run = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    bus.run = 1'b0;
    bus.ir  = 32'h0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (obs_s !== 61'h0) begin
        $display("FAIL reset cycle %0d: got %h expected %h", k, obs_s, 61'h0);
        errors++;
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs_s !== 61'h0) begin
      $display("FAIL idle_no_run: got %h expected %h", obs_s, 61'h0);
      errors++;
    end
  endtask

  task automatic test_shra();
    logic [60:0] exp [7];
    do_reset();
    bus.ir  = 32'h521B8000;
    bus.run = 1'b1;
    for (int k = 0; k < 3; k++) exp[k] = fetch(k);
    exp[3] = ev(YIN, 13'h0000, 16'h0008, 16'h0000, 1'b1, 1'b0, 1'b0);
    exp[4] = ev(ZIN, 13'h0080, 16'h0080, 16'h0000, 1'b1, 1'b0, 1'b0);
    exp[5] = ev(ZLO, 13'h0000, 16'h0000, 16'h0010, 1'b1, 1'b0, 1'b0);
    exp[6] = fetch(0);
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (obs_s !== exp[k]) begin
        $display("FAIL shra cycle %0d: got %h expected %h", k, obs_s, exp[k]);
        errors++;
      end
    end
  endtask

  task automatic test_mul();
    logic [60:0] exp [8];
    do_reset();
    bus.ir  = 32'h81880000;
    bus.run = 1'b1;
    for (int k = 0; k < 3; k++) exp[k] = fetch(k);
    exp[3] = ev(YIN, 13'h0000, 16'h0008, 16'h0000, 1'b1, 1'b0, 1'b0);
    exp[4] = ev(ZIN, 13'h0010, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0);
    exp[5] = ev(ZLO | LOIN, 13'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    exp[6] = ev(ZHI | HIIN, 13'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    exp[7] = fetch(0);
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (obs_s !== exp[k]) begin
        $display("FAIL mul cycle %0d: got %h expected %h", k, obs_s, exp[k]);
        errors++;
      end
    end
  endtask

  task automatic test_neg();
    logic [60:0] exp [6];
    do_reset();
    bus.ir  = 32'h89280000;
    bus.run = 1'b1;
    for (int k = 0; k < 3; k++) exp[k] = fetch(k);
    exp[3] = ev(ZIN, 13'h0800, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b0);
    exp[4] = ev(ZLO, 13'h0000, 16'h0000, 16'h0004, 1'b1, 1'b0, 1'b0);
    exp[5] = fetch(0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (obs_s !== exp[k]) begin
        $display("FAIL neg cycle %0d: got %h expected %h", k, obs_s, exp[k]);
        errors++;
      end
    end
  endtask

  task automatic test_illegal();
    logic [60:0] exp [13];
    do_reset();
    bus.ir  = 32'hF8000000;
    bus.run = 1'b1;
    for (int k = 0; k < 3; k++) exp[k] = fetch(k);
    for (int k = 3; k < 13; k++) exp[k] = ev(13'h0, 13'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 13; k++) begin
      tick();
      checks++;
      if (obs_s !== exp[k]) begin
        $display("FAIL illegal cycle %0d: got %h expected %h", k, obs_s, exp[k]);
        errors++;
      end
    end
    bus.run = 1'b0;
    reset   = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (obs_s !== 61'h0) begin
      $display("FAIL illegal_clear: got %h expected %h", obs_s, 61'h0);
      errors++;
    end
    tick();
    checks++;
    if (obs_s !== 61'h0) begin
      $display("FAIL illegal_idle: got %h expected %h", obs_s, 61'h0);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    logic [60:0] exp [5];
    do_reset();
    bus.ir  = 32'h18918000;
    bus.run = 1'b1;
    for (int k = 0; k < 3; k++) exp[k] = fetch(k);
    exp[3] = ev(YIN, 13'h0000, 16'h0004, 16'h0000, 1'b1, 1'b0, 1'b0);
    exp[4] = ev(ZIN, 13'h0004, 16'h0008, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (obs_s !== exp[k]) begin
        $display("FAIL reset_mid cycle %0d: got %h expected %h", k, obs_s, exp[k]);
        errors++;
      end
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (obs_s !== 61'h0) begin
      $display("FAIL reset_mid_abort: got %h expected %h", obs_s, 61'h0);
      errors++;
    end
    tick();
    checks++;
    if (obs_s !== fetch(0)) begin
      $display("FAIL reset_mid_resume: got %h expected %h", obs_s, fetch(0));
      errors++;
    end
  endtask

  task automatic test_run_drop();
    logic [60:0] exp [9];
    do_reset();
    bus.ir  = 32'h18918000;
    bus.run = 1'b1;
    for (int k = 0; k < 3; k++) exp[k] = fetch(k);
    exp[3] = ev(YIN, 13'h0000, 16'h0004, 16'h0000, 1'b1, 1'b0, 1'b0);
    exp[4] = ev(ZIN, 13'h0004, 16'h0008, 16'h0000, 1'b1, 1'b0, 1'b0);
    exp[5] = ev(ZLO, 13'h0000, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0);
    for (int k = 6; k < 9; k++) exp[k] = 61'h0;
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if (obs_s !== exp[k]) begin
        $display("FAIL run_drop cycle %0d: got %h expected %h", k, obs_s, exp[k]);
        errors++;
      end
      if (k == 3) bus.run = 1'b0;
    end
  endtask

  task automatic test_nop_halt();
    logic [60:0] exp [7];
    do_reset();
    bus.ir  = 32'hD0000000;
    bus.run = 1'b1;
    exp[0] = fetch(0);
    exp[1] = fetch(1);
    exp[2] = fetch(2);
    exp[3] = fetch(0);
    exp[4] = fetch(1);
    exp[5] = fetch(2);
    exp[6] = 61'h0;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (obs_s !== exp[k]) begin
        $display("FAIL nop cycle %0d: got %h expected %h", k, obs_s, exp[k]);
        errors++;
      end
      if (k == 4) bus.run = 1'b0;
    end
    do_reset();
    bus.ir  = 32'hD8000000;
    bus.run = 1'b1;
    exp[3] = ev(13'h0, 13'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    exp[4] = exp[3];
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (obs_s !== exp[k]) begin
        $display("FAIL halt cycle %0d: got %h expected %h", k, obs_s, exp[k]);
        errors++;
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    bus.run = 1'b0;
    bus.ir  = 32'h0;
    test_reset();
    test_shra();
    test_mul();
    test_neg();
    test_illegal();
    test_reset_mid();
    test_run_drop();
    test_nop_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
